blink_rate_ctrl: RTL and testbench
==================================

Name: blink_rate_ctrl

Overview:
Front-end stage for the LED blink path on the Tang Nano 9K (27 MHz). It takes one raw push-button, synchronises and debounces it, and cycles a 2-bit rate index on each press. It produces a one-cycle toggle-enable tick at the selected rate, which the downstream LED toggle stage consumes in place of its fixed 27M-cycle terminal count.

Parameters:
- DEBOUNCE_CYC, 270000, consecutive stable cycles needed to accept a new button level (10 ms at 27 MHz); must be >= 2.
- DIV0, 27000000, tick period in cycles for rate index 0 (1 toggle/s).
- DIV1, 13500000, tick period for index 1.
- DIV2, 6750000, tick period for index 2.
- DIV3, 3375000, tick period for index 3; every DIVn must be >= 2.
- CNT_W, 25, width of the tick counter; must satisfy DIVn-1 < 2^CNT_W.

Ports:
- CLK  in  1  system clock, 27 MHz.
- RESETn  in  1  asynchronous active-low reset.
- iBtn  in  1  raw button pad, active-low (pressed = 0), asynchronous to CLK.
- oTick  out  1  one-cycle pulse at the end of each period of the selected rate.
- oRateIdx  out  2  current rate index.
- oBtnPress  out  1  one-cycle pulse per accepted press.

Interface: reset RESETn, asynchronous, active-low; clock CLK. All outputs are registered.

Behaviour:
- Reset values:
  - 2-FF synchroniser = 1,1.
  - debounced level rBtnStable = 1.
  - debounce counter = 0.
  - oBtnPress = 0.
  - oRateIdx = 0.
  - tick counter rCnt = 0.
  - oTick = 0.
- Reset asserted mid-operation returns every register to these values immediately, with no pending pulse.
- Synchroniser: iBtn passes through 2 flops; the debouncer sees only the second flop (sBtn).
- Debounce:
  - If sBtn == rBtnStable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, rBtnStable <= sBtn and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes rBtnStable.
- Press detect:
  - A 1->0 transition of rBtnStable asserts oBtnPress for exactly 1 cycle, in the cycle after the transition.
  - A 0->1 transition (release) produces no event.
  - Pad-to-oBtnPress latency = 2 (sync) + DEBOUNCE_CYC + 1 cycles.
- Rate index:
  - Increments by 1 in the same cycle oBtnPress is high (visible the following cycle).
  - Wraps 3 -> 0.
- Tick generator:
  - Terminal T = DIV[oRateIdx]-1.
  - If rCnt >= T: rCnt <= 0 and oTick <= 1.
  - Otherwise rCnt <= rCnt+1 and oTick <= 0.
  - The >= comparison guarantees no overrun if the terminal shrinks.
  - First tick after reset release appears DIV0 cycles later; the steady period is exactly DIVn cycles.
- Rate change: in the cycle oBtnPress is high, rCnt <= 0 and oTick <= 0, which restarts the phase. The next tick arrives DIV[new] cycles later.
- Simultaneous press and terminal count: the press wins; no tick is issued and the counter restarts.
- A button held down indefinitely yields exactly one press.

Decomposition:
- Shared package/header blink_pkg:
  - CLK_HZ = 27000000.
  - CNT_W.
  - default DIV0..DIV3 and DEBOUNCE_CYC constants, also used by the downstream toggle stage.
- One sub-module, btn_debounce:
  - contains the synchroniser, debouncer and press-edge pulse.
  - ports: CLK, RESETn, iBtn, oLevel, oPress.
  - parameter DEBOUNCE_CYC.
- The rate index and tick generator stay in the top module.

Test Plan (simulation overrides DEBOUNCE_CYC=4, DIV0..3=8,6,4,2, CNT_W=4):
- Reset release, iBtn=1 held -> oRateIdx=0, oBtnPress never high, oTick high on cycle 8 after release and then every 8 cycles, single-cycle wide.
- iBtn low for 3 cycles then high -> no oBtnPress, oRateIdx stays 0, tick cadence undisturbed.
- iBtn low and held for 20 cycles -> one oBtnPress exactly 2+4+1 = 7 cycles after the falling edge, oRateIdx=1, counter restarted, ticks every 6 cycles. Release after 20 cycles produces no press.
- Four debounced presses -> oRateIdx sequence 1,2,3,0, tick periods 6,4,2,8; with index 3, oTick pulses every 2nd cycle.
- Press timed so oBtnPress coincides with rCnt==T -> no oTick that cycle; next oTick exactly DIV[new] cycles later.
- RESETn pulsed low mid-count with oRateIdx=2 and the debouncer mid-count -> all outputs 0 asynchronously; after release, behaviour matches the first scenario.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants and types for the LED blink path (27 MHz Tang Nano 9K).
// The downstream toggle stage uses the same defaults.
package blink_pkg;

    localparam int unsigned CLK_HZ           = 27000000;
    localparam int unsigned DEF_CNT_W        = 25;
    localparam int unsigned DEF_DEBOUNCE_CYC = 270000;
    localparam int unsigned DEF_DIV0         = 27000000;
    localparam int unsigned DEF_DIV1         = 13500000;
    localparam int unsigned DEF_DIV2         = 6750000;
    localparam int unsigned DEF_DIV3         = 3375000;

    typedef logic [1:0] rate_idx_t;

    // Natural 2-bit overflow gives the 3 -> 0 wrap.
    function automatic rate_idx_t next_rate(rate_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchroniser, stable-count debouncer and a one-cycle
// pulse on each accepted press (falling edge of the debounced, active-low level).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = blink_pkg::DEF_DEBOUNCE_CYC
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic iBtn,
    output logic oLevel,
    output logic oPress
);
    import blink_pkg::*;

    localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            s_btn;

    assign s_btn = sync_q[1];

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s_btn == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d = s_btn;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Edge taken from the registered level, so the pulse lands one cycle after the flip.
        press_d = level_dly_q & ~level_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sync_q      <= 2'b11;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], iBtn};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
        end
    end

    assign oLevel = level_q;
    assign oPress = press_q;

endmodule

// File: rtl/blink_rate_ctrl.sv
// Blink rate front end: each debounced press steps a 2-bit rate index, and a
// counter emits a one-cycle toggle-enable tick at the selected period.
module blink_rate_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = blink_pkg::DEF_DEBOUNCE_CYC,
    parameter int unsigned DIV0         = blink_pkg::DEF_DIV0,
    parameter int unsigned DIV1         = blink_pkg::DEF_DIV1,
    parameter int unsigned DIV2         = blink_pkg::DEF_DIV2,
    parameter int unsigned DIV3         = blink_pkg::DEF_DIV3,
    parameter int unsigned CNT_W        = blink_pkg::DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       iBtn,
    output logic       oTick,
    output logic [1:0] oRateIdx,
    output logic       oBtnPress
);
    import blink_pkg::*;

    localparam logic [CNT_W-1:0] Term0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] Term1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] Term2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] Term3 = CNT_W'(DIV3 - 1);

    rate_idx_t        idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] term;
    logic             btn_press;
    logic             unused_btn_level;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .CLK   (CLK),
        .RESETn(RESETn),
        .iBtn  (iBtn),
        .oLevel(unused_btn_level),
        .oPress(btn_press)
    );

    always_comb begin
        unique case (idx_q)
            2'd0: term = Term0;
            2'd1: term = Term1;
            2'd2: term = Term2;
            2'd3: term = Term3;
            default: term = Term0;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        // A press restarts the phase and suppresses any coincident terminal tick.
        if (btn_press) begin
            idx_d = next_rate(idx_q);
            cnt_d = '0;
        end else if (cnt_q >= term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            idx_q  <= 2'd0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign oTick     = tick_q;
    assign oRateIdx  = idx_q;
    assign oBtnPress = btn_press;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Bench for blink_rate_ctrl with small debounce/divider settings; every cycle is
// compared against a timeline model built from press times and tick deadlines.
module tb_blink_rate_ctrl;

    localparam int unsigned DEB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn   = 1'b1;
    logic       tick;
    logic [1:0] idx;
    logic       press;

    always #5 clk = ~clk;

    blink_rate_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .DIV0        (8),
        .DIV1        (6),
        .DIV2        (4),
        .DIV3        (2),
        .CNT_W       (4)
    ) dut (
        .CLK      (clk),
        .RESETn   (rst_n),
        .iBtn     (btn),
        .oTick    (tick),
        .oRateIdx (idx),
        .oBtnPress(press)
    );

    typedef struct {
        int low_cyc;
        int high_cyc;
        int exp_presses;
        int exp_lat;
        int exp_idx;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int  m_time, m_next, m_idx;
    bit  m_press, m_tick, m_fell_prev, m_stable, m_s1, m_s2;
    bit  win[$];

    vec_t vecs[6];
    int   k, first, cnt;

    function automatic int div_of(input int i);
        case (i)
            0: return 8;
            1: return 6;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic void model_reset();
        m_time = 0; m_next = div_of(0); m_idx = 0;
        m_press = 0; m_tick = 0; m_fell_prev = 0;
        m_stable = 1; m_s1 = 1; m_s2 = 1;
        win = {};
        for (int i = 0; i < int'(DEB); i++) win.push_back(1'b1);
    endfunction

    // A new level is accepted once the last DEB synchronised samples all differ from it.
    function automatic void model_edge();
        bit seen, old_press, all_diff, fell_now;
        seen = m_s2; m_s2 = m_s1; m_s1 = btn;
        win.push_back(seen);
        void'(win.pop_front());
        all_diff = 1;
        foreach (win[i]) if (win[i] == m_stable) all_diff = 0;
        fell_now = 0;
        if (all_diff) begin
            fell_now = m_stable;
            m_stable = ~m_stable;
        end
        old_press   = m_press;
        m_press     = m_fell_prev;
        m_fell_prev = fell_now;
        m_time++;
        if (old_press) begin
            m_idx  = (m_idx + 1) % 4;
            m_next = m_time + div_of(m_idx);
            m_tick = 0;
        end else if (m_time == m_next) begin
            m_tick = 1;
            m_next = m_time + div_of(m_idx);
        end else begin
            m_tick = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tick", 32'(tick), 32'(m_tick));
        check("rate_idx", 32'(idx), 32'(m_idx));
        check("btn_press", 32'(press), 32'(m_press));
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases on a negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_press", 32'(press), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        btn   = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick && n < 40);
    endtask

    task automatic press_once();
        btn = 1'b0;
        repeat (8) cycle();
        btn = 1'b1;
        repeat (8) cycle();
    endtask

    initial begin
        vecs[0] = '{low_cyc: 3,  high_cyc: 12, exp_presses: 0, exp_lat: 0, exp_idx: 0};
        vecs[1] = '{low_cyc: 20, high_cyc: 12, exp_presses: 1, exp_lat: 7, exp_idx: 1};
        vecs[2] = '{low_cyc: 4,  high_cyc: 12, exp_presses: 1, exp_lat: 7, exp_idx: 2};
        vecs[3] = '{low_cyc: 6,  high_cyc: 12, exp_presses: 1, exp_lat: 7, exp_idx: 3};
        vecs[4] = '{low_cyc: 6,  high_cyc: 12, exp_presses: 1, exp_lat: 7, exp_idx: 0};
        vecs[5] = '{low_cyc: 1,  high_cyc: 10, exp_presses: 0, exp_lat: 0, exp_idx: 0};

        // Reset release with button idle: first tick on cycle 8, then every 8.
        do_reset();
        wait_tick(k);
        check("first_tick_cycle", 32'(k), 32'd8);
        wait_tick(k);
        check("idle_tick_period", 32'(k), 32'd8);

        // Table of press shapes: glitch, long hold, exact-threshold and short presses.
        for (int v = 0; v < 6; v++) begin
            k = 0; first = 0; cnt = 0;
            btn = 1'b0;
            for (int c = 0; c < vecs[v].low_cyc + vecs[v].high_cyc; c++) begin
                if (c == vecs[v].low_cyc) btn = 1'b1;
                cycle();
                k++;
                if (press) begin
                    cnt++;
                    if (first == 0) first = k;
                end
            end
            check($sformatf("vec%0d_presses", v), 32'(cnt), 32'(vecs[v].exp_presses));
            check($sformatf("vec%0d_latency", v), 32'(first), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_rate_idx", v), 32'(idx), 32'(vecs[v].exp_idx));
        end

        // Press lands on the terminal-count cycle: press wins, next tick DIV1 later.
        do_reset();
        repeat (8) cycle();
        check("collide_pre_tick", 32'(tick), 32'd1);
        btn = 1'b0;
        repeat (7) cycle();
        check("collide_press", 32'(press), 32'd1);
        cycle();
        check("collide_no_tick", 32'(tick), 32'd0);
        check("collide_rate_idx", 32'(idx), 32'd1);
        wait_tick(k);
        check("collide_next_tick", 32'(k), 32'd6);
        repeat (10) cycle();
        btn = 1'b1;
        repeat (10) cycle();

        // Random button activity against the model.
        for (int r = 0; r < 80; r++) begin
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 9)) cycle();
        end
        btn = 1'b1;
        repeat (12) cycle();

        // Reset mid-count with index 2 and the debouncer part-way through a press.
        do_reset();
        press_once();
        press_once();
        check("pre_reset_rate_idx", 32'(idx), 32'd2);
        btn = 1'b0;
        repeat (3) cycle();
        do_reset();
        cnt = 0;
        wait_tick(k);
        check("post_reset_first_tick", 32'(k), 32'd8);
        check("post_reset_rate_idx", 32'(idx), 32'd0);
        wait_tick(k);
        check("post_reset_tick_period", 32'(k), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
